// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and the default address width.
// The read-side controller imports this package as well.
package fifo_pkg;

  localparam int FIFO_ADDRSIZE = 4;

  // Mask with the low w bits set. Callers zero-extend into 32 bits.
  function automatic logic [31:0] width_mask(input int unsigned w);
    return (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b, input int unsigned w);
    logic [31:0] bm;
    bm = b & width_mask(w);
    return bm ^ (bm >> 1);
  endfunction

  // Bit i is the XOR of all Gray bits at or above i.
  function automatic logic [31:0] gray2bin(input logic [31:0] g, input int unsigned w);
    logic [31:0] gm;
    logic [31:0] b;
    gm    = g & width_mask(w);
    b     = '0;
    b[31] = gm[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ gm[i];
    return b;
  endfunction

endpackage

// File: rtl/wptr_full_if.sv
// Write-side bus of the async FIFO: upstream request, synchronized read pointer,
// and the flags/pointers produced by the write-pointer controller.
interface wptr_full_if #(
  parameter int ADDRSIZE = 4
);
  logic                winc;
  logic [ADDRSIZE:0]   wq2_rptr;
  logic                wovf_clr;
  logic                wen;
  logic [ADDRSIZE-1:0] waddr;
  logic [ADDRSIZE:0]   wptr;
  logic                wfull;
  logic                wafull;
  logic [ADDRSIZE:0]   wlevel;
  logic                wovf;

  // Upstream writer / surrounding FIFO logic.
  modport master (
    output winc, wq2_rptr, wovf_clr,
    input  wen, waddr, wptr, wfull, wafull, wlevel, wovf
  );

  // Write-pointer controller.
  modport slave (
    input  winc, wq2_rptr, wovf_clr,
    output wen, waddr, wptr, wfull, wafull, wlevel, wovf
  );
endinterface

// File: rtl/wptr_full_gray2bin.sv
// Combinational Gray-to-binary converter, parameterised width.
// Each output bit is a reduction XOR of the Gray bits at and above it, so there
// is no ripple chain through the output vector itself.
module gray2bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Per-bit prefix XOR from the MSB down.
  always_comb begin
    bin = '0;
    for (int i = 0; i < W; i++) bin[i] = ^(gray >> i);
  end

endmodule

// File: rtl/wptr_full.sv
// Write-domain pointer/flag controller for the async FIFO. Owns the binary write
// address and the Gray pointer sent to the read side; derives full, almost-full,
// fill level and a sticky overflow flag from the synchronized read pointer.
module wptr_full import fifo_pkg::*; #(
  parameter int ADDRSIZE    = FIFO_ADDRSIZE,
  parameter int AFULL_LEVEL = 12
) (
  input logic        wclk,
  input logic        wrst,
  wptr_full_if.slave bus
);

  localparam int            PW        = ADDRSIZE + 1;
  localparam logic [PW-1:0] AFULL_THR = PW'(AFULL_LEVEL);

  logic [PW-1:0] wbin, wbinnext, wgraynext, rbin_s, level_next;
  logic [PW-1:0] wptr_q, wlevel_q;
  logic          wfull_q, wafull_q, wovf_q;
  logic          accept, ovf, wfull_val;

  // A write goes through only while not full; a write against full is dropped.
  assign accept = bus.winc & ~wfull_q;
  assign ovf    = bus.winc &  wfull_q;

  assign wbinnext  = wbin + PW'(accept);
  assign wgraynext = PW'(bin2gray(32'(wbinnext), PW));

  // Full when the next write pointer is exactly one lap ahead of the read
  // pointer: in Gray that means the top two bits inverted, the rest equal.
  assign wfull_val = (wgraynext == {~bus.wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                                    bus.wq2_rptr[ADDRSIZE-2:0]});

  gray2bin #(.W(PW)) u_rptr_g2b (
    .gray (bus.wq2_rptr),
    .bin  (rbin_s)
  );

  // Modular subtraction stays correct across the pointer wrap. The level is
  // pessimistic because the read pointer arrives through a synchronizer.
  assign level_next = wbinnext - rbin_s;

  // Pointer and flag registers; all flags reflect this cycle's accepted write.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin     <= '0;
      wptr_q   <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wlevel_q <= '0;
    end else begin
      wbin     <= wbinnext;
      wptr_q   <= wgraynext;
      wfull_q  <= wfull_val;
      wafull_q <= (level_next >= AFULL_THR);
      wlevel_q <= level_next;
    end
  end

  // Sticky overflow; a fresh overflow beats a same-cycle clear.
  always_ff @(posedge wclk) begin
    if (wrst)              wovf_q <= 1'b0;
    else if (ovf)          wovf_q <= 1'b1;
    else if (bus.wovf_clr) wovf_q <= 1'b0;
  end

  assign bus.wen    = accept;
  assign bus.waddr  = wbin[ADDRSIZE-1:0];
  assign bus.wptr   = wptr_q;
  assign bus.wfull  = wfull_q;
  assign bus.wafull = wafull_q;
  assign bus.wlevel = wlevel_q;
  assign bus.wovf   = wovf_q;

endmodule

// File: tb/tb_wptr_full.sv
// Bench for wptr_full (ADDRSIZE=4, AFULL_LEVEL=12). The reference model counts
// writes and reads as unbounded integers: occupancy is simply wr - rd, full is
// occupancy == 16, and the expected pointers are those counts folded mod 32.
module tb_wptr_full;

  localparam int AW    = 4;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 16;
  localparam int AFL   = 12;

  logic wclk = 1'b0;
  logic wrst;
  always #5 wclk = ~wclk;

  wptr_full_if #(.ADDRSIZE(AW)) bus ();

  wptr_full #(.ADDRSIZE(AW), .AFULL_LEVEL(AFL)) dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int   wr, rd, mlevel;
  logic mfull, movf;
  logic wen_pre, exp_wen;

  function automatic logic [PW-1:0] gray(input int x);
    logic [PW-1:0] b;
    b = PW'(x % 32);
    return b ^ (b >> 1);
  endfunction

  // One write-clock cycle: drive inputs, sample wen before the edge, advance
  // the model at the edge, return 1 time unit after the edge.
  task automatic cyc(input logic inc, input logic clr, input int rd_new, input logic rst);
    logic acc, novf;
    bus.winc     = inc;
    bus.wovf_clr = clr;
    rd           = rd_new;
    bus.wq2_rptr = gray(rd);
    wrst         = rst;
    #1;
    wen_pre = bus.wen;
    exp_wen = inc & ~mfull;
    @(posedge wclk);
    if (rst) begin
      wr = 0; rd = 0; mlevel = 0; mfull = 1'b0; movf = 1'b0;
    end else begin
      acc  = inc & ~mfull;
      novf = inc &  mfull;
      wr   = wr + int'(acc);
      mlevel = wr - rd;
      mfull  = (mlevel == DEPTH);
      if (novf)     movf = 1'b1;
      else if (clr) movf = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b1, 0, 1'b1);
    cyc(1'b0, 1'b0, 0, 1'b1);
    cyc(1'b0, 1'b0, 0, 1'b0);
    checks++; if (bus.wptr !== 5'd0)   begin errors++; $display("FAIL reset_wptr: got %b want 0", bus.wptr); end
    checks++; if (bus.wfull !== 1'b0)  begin errors++; $display("FAIL reset_wfull: got %b want 0", bus.wfull); end
    checks++; if (bus.wafull !== 1'b0) begin errors++; $display("FAIL reset_wafull: got %b want 0", bus.wafull); end
    checks++; if (bus.wlevel !== 5'd0) begin errors++; $display("FAIL reset_wlevel: got %0d want 0", bus.wlevel); end
    checks++; if (bus.wovf !== 1'b0)   begin errors++; $display("FAIL reset_wovf: got %b want 0", bus.wovf); end
    checks++; if (bus.waddr !== 4'd0)  begin errors++; $display("FAIL reset_waddr: got %0d want 0", bus.waddr); end
    bus.winc = 1'b1; #1;
    checks++; if (bus.wen !== 1'b1)    begin errors++; $display("FAIL reset_wen: got %b want 1", bus.wen); end
    bus.winc = 1'b0; #1;
    checks++; if (bus.wen !== 1'b0)    begin errors++; $display("FAIL reset_wen_idle: got %b want 0", bus.wen); end
  endtask

  task automatic test_fill_full();
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(1'b1, 1'b0, 0, 1'b0);
      checks++; if (wen_pre !== 1'b1) begin errors++; $display("FAIL fill_wen[%0d]: got %b want 1", i, wen_pre); end
      checks++; if (bus.wlevel !== 5'(i)) begin errors++; $display("FAIL fill_wlevel[%0d]: got %0d want %0d", i, bus.wlevel, i); end
      checks++; if (bus.wafull !== (i >= AFL)) begin errors++; $display("FAIL fill_wafull[%0d]: got %b want %b", i, bus.wafull, i >= AFL); end
      checks++; if (bus.wfull !== (i == DEPTH)) begin errors++; $display("FAIL fill_wfull[%0d]: got %b want %b", i, bus.wfull, i == DEPTH); end
    end
    checks++; if (bus.wptr !== 5'b11000) begin errors++; $display("FAIL fill_wptr: got %b want 11000", bus.wptr); end
    checks++; if (bus.waddr !== 4'd0)    begin errors++; $display("FAIL fill_waddr: got %0d want 0", bus.waddr); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 0, 1'b0);
      checks++; if (wen_pre !== 1'b0)      begin errors++; $display("FAIL ovf_wen[%0d]: got %b want 0", i, wen_pre); end
      checks++; if (bus.wptr !== 5'b11000) begin errors++; $display("FAIL ovf_wptr[%0d]: got %b want 11000", i, bus.wptr); end
      checks++; if (bus.wovf !== 1'b1)     begin errors++; $display("FAIL ovf_set[%0d]: got %b want 1", i, bus.wovf); end
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0, 0, 1'b0);
      checks++; if (bus.wovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky[%0d]: got %b want 1", i, bus.wovf); end
    end
    cyc(1'b0, 1'b1, 0, 1'b0);
    checks++; if (bus.wovf !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b want 0", bus.wovf); end
    cyc(1'b1, 1'b1, 0, 1'b0);
    checks++; if (bus.wovf !== 1'b1) begin errors++; $display("FAIL ovf_clr_vs_new: got %b want 1", bus.wovf); end
    checks++; if (bus.wfull !== 1'b1) begin errors++; $display("FAIL ovf_still_full: got %b want 1", bus.wfull); end
  endtask

  task automatic test_drain();
    cyc(1'b0, 1'b0, 4, 1'b0);
    checks++; if (bus.wfull !== 1'b0)   begin errors++; $display("FAIL drain4_wfull: got %b want 0", bus.wfull); end
    checks++; if (bus.wlevel !== 5'd12) begin errors++; $display("FAIL drain4_wlevel: got %0d want 12", bus.wlevel); end
    checks++; if (bus.wafull !== 1'b1)  begin errors++; $display("FAIL drain4_wafull: got %b want 1", bus.wafull); end
    cyc(1'b0, 1'b0, 5, 1'b0);
    checks++; if (bus.wlevel !== 5'd11) begin errors++; $display("FAIL drain5_wlevel: got %0d want 11", bus.wlevel); end
    checks++; if (bus.wafull !== 1'b0)  begin errors++; $display("FAIL drain5_wafull: got %b want 0", bus.wafull); end
  endtask

  task automatic test_simul();
    for (int r = 6; r <= 8; r++) cyc(1'b0, 1'b0, r, 1'b0);
    checks++; if (bus.wlevel !== 5'd8) begin errors++; $display("FAIL simul_pre_level: got %0d want 8", bus.wlevel); end
    cyc(1'b1, 1'b0, 9, 1'b0);
    checks++; if (bus.wlevel !== 5'd8) begin errors++; $display("FAIL simul_level: got %0d want 8", bus.wlevel); end
    checks++; if (bus.wfull !== 1'b0)  begin errors++; $display("FAIL simul_wfull: got %b want 0", bus.wfull); end
    checks++; if (bus.wptr !== gray(17)) begin errors++; $display("FAIL simul_wptr: got %b want %b", bus.wptr, gray(17)); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 9, 1'b0);
    cyc(1'b1, 1'b0, 9, 1'b0);
    checks++; if (bus.wfull !== 1'b1) begin errors++; $display("FAIL rmid_pre_full: got %b want 1", bus.wfull); end
    checks++; if (bus.wovf !== 1'b1)  begin errors++; $display("FAIL rmid_pre_ovf: got %b want 1", bus.wovf); end
    cyc(1'b1, 1'b1, 9, 1'b1);
    checks++; if (bus.wptr !== 5'd0)   begin errors++; $display("FAIL rmid_wptr: got %b want 0", bus.wptr); end
    checks++; if (bus.wfull !== 1'b0)  begin errors++; $display("FAIL rmid_wfull: got %b want 0", bus.wfull); end
    checks++; if (bus.wovf !== 1'b0)   begin errors++; $display("FAIL rmid_wovf: got %b want 0", bus.wovf); end
    checks++; if (bus.wlevel !== 5'd0) begin errors++; $display("FAIL rmid_wlevel: got %0d want 0", bus.wlevel); end
    checks++; if (bus.wafull !== 1'b0) begin errors++; $display("FAIL rmid_wafull: got %b want 0", bus.wafull); end
    checks++; if (bus.waddr !== 4'd0)  begin errors++; $display("FAIL rmid_waddr: got %0d want 0", bus.waddr); end
  endtask

  task automatic test_wrap();
    cyc(1'b1, 1'b0, 0, 1'b0);
    cyc(1'b1, 1'b0, 0, 1'b0);
    // Write and read advance together: occupancy pinned at 2 through 31->0.
    for (int i = 0; i < 56; i++) begin
      cyc(1'b1, 1'b0, rd + 1, 1'b0);
      checks++; if (bus.wlevel !== 5'd2) begin errors++; $display("FAIL wrap_level[%0d]: got %0d want 2", i, bus.wlevel); end
      checks++; if (bus.wfull !== 1'b0)  begin errors++; $display("FAIL wrap_wfull[%0d]: got %b want 0", i, bus.wfull); end
      checks++; if (bus.wptr !== gray(wr)) begin errors++; $display("FAIL wrap_wptr[%0d]: got %b want %b", i, bus.wptr, gray(wr)); end
    end
    // Hold the read pointer; filling crosses wr=64 (pointer value 0).
    for (int i = 0; i < 15; i++) begin
      cyc(1'b1, 1'b0, rd, 1'b0);
      checks++; if (bus.wfull !== (mlevel == DEPTH)) begin errors++; $display("FAIL wrapfill_wfull[%0d]: got %b want %b", i, bus.wfull, mlevel == DEPTH); end
      checks++; if (bus.wlevel !== 5'(mlevel)) begin errors++; $display("FAIL wrapfill_level[%0d]: got %0d want %0d", i, bus.wlevel, mlevel); end
    end
    checks++; if (bus.wptr !== gray(72)) begin errors++; $display("FAIL wrapfill_wptr: got %b want %b", bus.wptr, gray(72)); end
    checks++; if (bus.wovf !== 1'b1)     begin errors++; $display("FAIL wrapfill_wovf: got %b want 1", bus.wovf); end
  endtask

  task automatic test_random();
    logic [PW-1:0] prev_ptr;
    logic inc, clr;
    int   rn;
    cyc(1'b0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      prev_ptr = bus.wptr;
      inc = ($urandom % 10) < 7;
      clr = ($urandom % 10) == 0;
      rn  = rd + (((rd < wr) && (($urandom % 10) < 4)) ? 1 : 0);
      cyc(inc, clr, rn, 1'b0);
      checks++; if (wen_pre !== exp_wen) begin errors++; $display("FAIL rnd_wen[%0d]: got %b want %b", i, wen_pre, exp_wen); end
      checks++; if (bus.wptr !== gray(wr)) begin errors++; $display("FAIL rnd_wptr[%0d]: got %b want %b", i, bus.wptr, gray(wr)); end
      checks++; if (bus.waddr !== 4'(wr % DEPTH)) begin errors++; $display("FAIL rnd_waddr[%0d]: got %0d want %0d", i, bus.waddr, wr % DEPTH); end
      checks++; if (bus.wfull !== mfull) begin errors++; $display("FAIL rnd_wfull[%0d]: got %b want %b", i, bus.wfull, mfull); end
      checks++; if (bus.wafull !== (mlevel >= AFL)) begin errors++; $display("FAIL rnd_wafull[%0d]: got %b want %b", i, bus.wafull, mlevel >= AFL); end
      checks++; if (bus.wlevel !== 5'(mlevel)) begin errors++; $display("FAIL rnd_wlevel[%0d]: got %0d want %0d", i, bus.wlevel, mlevel); end
      checks++; if (bus.wovf !== movf) begin errors++; $display("FAIL rnd_wovf[%0d]: got %b want %b", i, bus.wovf, movf); end
      checks++; if ($countones(bus.wptr ^ prev_ptr) > 1) begin errors++; $display("FAIL rnd_gray_step[%0d]: got %b from %b want at most one bit change", i, bus.wptr, prev_ptr); end
    end
  endtask

  initial begin
    wr = 0; rd = 0; mlevel = 0; mfull = 1'b0; movf = 1'b0;
    wrst = 1'b1; bus.winc = 1'b0; bus.wovf_clr = 1'b0; bus.wq2_rptr = '0;
    test_reset();
    test_fill_full();
    test_overflow();
    test_drain();
    test_simul();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
